// File: rtl/riscv_muldiv.sv
// riscv_muldiv: RV32M multiply/divide unit.
// Multiplies use a 32-step shift-add loop and divides a 32-step restoring
// shift-subtract loop. Both run on operand magnitudes, and the sign is applied
// on the way out. The result is written into `out` as the FSM enters DONE.
// Optional build macro MULDIV_FAST_MUL_EN replaces the iterative multiplier
// with a single-cycle 64-bit product. Divides are unchanged.
module riscv_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [63:0] acc_q;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q;   // multiplicand magnitude or divisor magnitude
  logic        neg_q;    // negate product / quotient
  logic        neg_r_q;  // negate remainder (dividend sign)
  logic [5:0]  cnt_q;
  logic [31:0] out_q;

  logic        accept;
  logic        signed_a, signed_b, sign_a, sign_b;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_trial;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_step;
  logic [63:0] step;
  logic [63:0] prod_signed;
  logic        last_iter;
  logic [31:0] result;

  // A start is ignored only while an operation is in flight.
  assign accept = start && (state_q != CALC);

  // Operand signedness by funct3. MULHU, DIVU and REMU are fully unsigned.
  // MULHSU has an unsigned rs2.
  assign signed_a = !(op == 3'b011 || op == 3'b101 || op == 3'b111);
  assign signed_b = (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b110);
  assign sign_a   = signed_a & inA[31];
  assign sign_b   = signed_b & inB[31];
  assign a_mag    = sign_a ? -inA : inA;
  assign b_mag    = sign_b ? -inB : inB;

  // One shift-add step: add the multiplicand into the high half when the
  // multiplier LSB is set, then shift the whole 64-bit accumulator right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_step = {mul_sum, acc_q[31:1]};

  // One restoring step: shift the next dividend bit into the remainder, and
  // keep the subtraction only if it does not go negative. A zero divisor
  // yields an all-ones quotient and the dividend magnitude as the remainder.
  assign div_trial = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_trial >= {1'b0, opnd_q});
  assign div_diff  = div_trial[31:0] - opnd_q;
  assign div_step  = {(div_ge ? div_diff : div_trial[31:0]), acc_q[30:0], div_ge};

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'd0, acc_q[31:0]} * {32'd0, opnd_q};
`endif

  // Select the datapath step for this cycle and detect the final CALC cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    step      = op_q[2] ? div_step : mul_step;
    last_iter = (cnt_q == 6'd31);
`ifdef MULDIV_FAST_MUL_EN
    if (!op_q[2]) begin
      step      = fast_prod;
      last_iter = 1'b1;
    end
`endif
  end

  // Apply signs to the final magnitudes and pick the half that the op returns.
  assign prod_signed = neg_q ? -step : step;
  always_comb begin
    result = prod_signed[31:0];
    case (op_q)
      3'b000:                 result = prod_signed[31:0];
      3'b001, 3'b010, 3'b011: result = prod_signed[63:32];
      3'b100, 3'b101:         result = neg_q ? -step[31:0] : step[31:0];
      default:                result = neg_r_q ? -step[63:32] : step[63:32];
    endcase
  end

  // Next-state logic: IDLE -> CALC -> DONE, and DONE may restart back-to-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers. Operands are latched on acceptance and stepped in CALC.
  // out is written only as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 3'b000;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= 6'd0;
      out_q   <= 32'd0;
    end else if (accept) begin
      op_q    <= op;
      acc_q   <= {32'd0, (op[2] ? a_mag : b_mag)};
      opnd_q  <= op[2] ? b_mag : a_mag;
      neg_q   <= (sign_a ^ sign_b) & !(op[2] && (inB == 32'd0));
      neg_r_q <= sign_a;
      cnt_q   <= 6'd0;
    end else if (state_q == CALC) begin
      acc_q <= step;
      cnt_q <= cnt_q + 6'd1;
      if (last_iter) out_q <= result;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed vector table plus hand-written sequences for
// held start, back-to-back restart and reset in the middle of CALC.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] inA, inB;
  logic        busy, done;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  riscv_muldiv dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .inA  (inA),
    .inB  (inB),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one operation. The operand inputs are scrambled right after the
  // accepting edge. Return the result and the number of edges to done.
  // A latency of 0 means the wait timed out.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit release_rst, output logic [31:0] res, output int lat);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    start = 1'b1; op = o; inA = a; inB = b;
    @(posedge clk); #1;
    start = 1'b0; inA = ~a; inB = ~b;
    lat = 0; res = 32'd0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; res = out; break; end
    end
  endtask

  initial begin
    logic [31:0] res;
    int          lat, exp_lat, n_done;

    vecs[0]  = '{"mul_7_m3",       3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{"mulh_min_m1",    3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[2]  = '{"mulhsu_min_m1",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[3]  = '{"mulhu_min_m1",   3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    vecs[4]  = '{"div_m20_3",      3'b100, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA};
    vecs[5]  = '{"rem_m20_3",      3'b110, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE};
    vecs[6]  = '{"divu_20_3",      3'b101, 32'h00000014, 32'h00000003, 32'h00000006};
    vecs[7]  = '{"divu_by0",       3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF};
    vecs[8]  = '{"remu_by0",       3'b111, 32'h12345678, 32'h00000000, 32'h12345678};
    vecs[9]  = '{"div_ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[10] = '{"rem_ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[11] = '{"mul_m1_m1",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[12] = '{"mulhu_max_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[13] = '{"div_7_m2",       3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[14] = '{"rem_7_m2",       3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001};
    vecs[15] = '{"div_m5_by0",     3'b100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF};
    vecs[16] = '{"rem_m5_by0",     3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB};
    vecs[17] = '{"remu_20_3",      3'b111, 32'h00000014, 32'h00000003, 32'h00000002};
    vecs[18] = '{"mulhsu_m1_2",    3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[19] = '{"mulh_2p30_4",    3'b001, 32'h40000000, 32'h00000004, 32'h00000001};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; inA = 32'd0; inB = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out",  out, 32'd0);

    // Table. The first entry is issued on the same negedge that releases reset.
    for (int i = 0; i < 20; i++) begin
      exp_lat = vecs[i].op[2] ? DIV_LAT : MUL_LAT;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 0), res, lat);
      check({vecs[i].name, "_out"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, exp_lat);
      @(posedge clk); #1;
      check({vecs[i].name, "_pulse"}, {30'd0, busy, done}, 32'd0);
    end

    // Hold start through CALC while inA keeps changing. Expect exactly one
    // done, with the result computed from the latched 100/7.
    @(negedge clk);
    start = 1'b1; op = 3'b101; inA = 32'd100; inB = 32'd7;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      check("held_busy", {31'd0, busy}, 32'd1);
      inA = 32'h11111111 * i;
    end
    check("held_lat", lat, DIV_LAT);
    check("held_out", out, 32'd14);

    // start is still high in DONE, so the next edge accepts 50/7 back-to-back.
    inA = 32'd50; inB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_out_held", out, 32'd14);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    check("b2b_lat", lat, DIV_LAT);
    check("b2b_out", out, 32'd7);

    // Reset during iteration 15 of a divide. Outputs must clear before the
    // next clock edge, and no done pulse may follow.
    @(negedge clk);
    start = 1'b1; op = 3'b100; inA = 32'hFFFFFFEC; inB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_out", out, 32'd7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_out", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("post_rst_quiet", n_done, 32'd0);

    // Recovery after the aborted operation.
    run_op(3'b011, 32'hFFFFFFFF, 32'h00000002, 1'b0, res, lat);
    check("recover_out", res, 32'h00000001);
    check("recover_lat", lat, MUL_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
